ghost_box_renderer: RTL and testbench

//  Pipelined, parametrised pixel generator for the ghost-house box sprite.
//  - Replaces the fixed all-white box graphic.
//  - Configurable size, colours, border outline, blinking mode and out-of-range transparency.
//  - Sits between the VGA pixel-coordinate path and the sprite colour mux.
//  - Returns one pixel per cycle with fixed latency.

---
 rtl/ghost_box_renderer.sv | 160 ++++++++++++++++
 tb/tb_ghost_box_renderer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_box_renderer.sv
// Box-sprite pixel generator. It takes relative x/y requests and returns one
// RGB332 pixel per cycle, two cycles after each request.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_NORMAL  | blink_phase=0, BLINK mode shows the border colour on the edge
// ST_SWAPPED | blink_phase=1, BLINK mode swaps the fill and border colours
module ghost_box_renderer #(
    parameter int PIXELS_WIDTH = 16,
    parameter int REL_BITS = 5,
    parameter int PIXEL_COLOR_BITS = 8,
    parameter logic [PIXEL_COLOR_BITS-1:0] TRANSPARENT_COLOR = 8'h00,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_tick,
    input  logic [1:0]                  mode,
    input  logic [PIXEL_COLOR_BITS-1:0] fill_color,
    input  logic [PIXEL_COLOR_BITS-1:0] border_color,
    input  logic                        req_valid,
    input  logic [REL_BITS-1:0]         x,
    input  logic [REL_BITS-1:0]         y,
    output logic                        pix_valid,
    output logic [PIXEL_COLOR_BITS-1:0] pixels,
    output logic                        blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [REL_BITS-1:0] REL_LAST = REL_BITS'(PIXELS_WIDTH - 1);

    localparam logic [1:0] MODE_SOLID  = 2'd0;
    localparam logic [1:0] MODE_BORDER = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_SWAPPED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                        s1_valid_q, s1_valid_d;
    logic [REL_BITS-1:0]         s1_x_q, s1_x_d;
    logic [REL_BITS-1:0]         s1_y_q, s1_y_d;
    logic [1:0]                  s1_mode_q, s1_mode_d;
    logic [PIXEL_COLOR_BITS-1:0] s1_fill_q, s1_fill_d;
    logic [PIXEL_COLOR_BITS-1:0] s1_border_q, s1_border_d;

    logic                        pix_valid_q, pix_valid_d;
    logic [PIXEL_COLOR_BITS-1:0] pixels_q, pixels_d;

    logic                        in_range;
    logic                        on_edge;
    logic [PIXEL_COLOR_BITS-1:0] colour;

    // Blink FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Blink FSM: next state. Leaving BLINK clears the counter even on a tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mode != MODE_BLINK) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
        end else if (frame_tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                case (state_q)
                    ST_NORMAL:  state_d = ST_SWAPPED;
                    ST_SWAPPED: state_d = ST_NORMAL;
                    default:    state_d = ST_NORMAL;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Blink FSM: outputs
    always_comb begin
        blink_phase = (state_q == ST_SWAPPED);
    end

    always_comb begin
        s1_valid_d  = req_valid;
        s1_x_d      = x;
        s1_y_d      = y;
        s1_mode_d   = mode;
        s1_fill_d   = fill_color;
        s1_border_d = border_color;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_mode_q   <= '0;
            s1_fill_q   <= '0;
            s1_border_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_mode_q   <= s1_mode_d;
            s1_fill_q   <= s1_fill_d;
            s1_border_q <= s1_border_d;
        end
    end

    // Colour mux on stage-1 data; the range check overrides every mode.
    always_comb begin
        in_range = (s1_x_q <= REL_LAST) && (s1_y_q <= REL_LAST);
        on_edge  = (s1_x_q == '0) || (s1_y_q == '0) ||
                   (s1_x_q == REL_LAST) || (s1_y_q == REL_LAST);
        colour   = TRANSPARENT_COLOR;
        if (in_range) begin
            case (s1_mode_q)
                MODE_SOLID:  colour = s1_fill_q;
                MODE_BORDER: colour = on_edge ? s1_border_q : s1_fill_q;
                MODE_BLINK:  colour = (on_edge ^ blink_phase) ? s1_border_q : s1_fill_q;
                default:     colour = TRANSPARENT_COLOR;
            endcase
        end
    end

    always_comb begin
        pix_valid_d = s1_valid_q;
        pixels_d    = pixels_q;
        if (s1_valid_q) begin
            pixels_d = colour;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            pixels_q    <= '0;
        end else begin
            pix_valid_q <= pix_valid_d;
            pixels_q    <= pixels_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pixels    = pixels_q;

endmodule

// File: tb/tb_ghost_box_renderer.sv
// Scoreboard bench for ghost_box_renderer: directed requests push their expected
// pixel and the cycle at which it should appear, and a monitor checks each output.
module tb_ghost_box_renderer;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic [1:0] mode;
    logic [7:0] fill_color;
    logic [7:0] border_color;
    logic       req_valid;
    logic [4:0] x;
    logic [4:0] y;
    logic       pix_valid;
    logic [7:0] pixels;
    logic       blink_phase;

    typedef struct {
        logic [7:0] pix;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ghost_box_renderer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .mode         (mode),
        .fill_color   (fill_color),
        .border_color (border_color),
        .req_valid    (req_valid),
        .x            (x),
        .y            (y),
        .pix_valid    (pix_valid),
        .pixels       (pixels),
        .blink_phase  (blink_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid output must match the oldest expectation, on time.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && pix_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_pix_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("pixel", int'(pixels), int'(e.pix));
                    chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input int xx, input int yy, input logic [1:0] m,
                        input logic [7:0] f, input logic [7:0] b, input logic [7:0] e);
        exp_t item;
        @(negedge clk);
        req_valid    = 1'b1;
        x            = 5'(xx);
        y            = 5'(yy);
        mode         = m;
        fill_color   = f;
        border_color = b;
        item.pix = e;
        item.cyc = cyc + 2;
        q.push_back(item);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        mode = m;
    endtask

    initial begin
        rst_n        = 1'b1;
        frame_tick   = 1'b0;
        mode         = 2'd0;
        fill_color   = 8'h00;
        border_color = 8'h00;
        req_valid    = 1'b0;
        x            = '0;
        y            = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_pixels", pixels, 0);
        chk("reset_blink_phase", blink_phase, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // SOLID sweep plus out-of-range
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++)
                send(xx, yy, 2'd0, 8'hFF, 8'hE0, 8'hFF);
        send(16, 3, 2'd0, 8'hFF, 8'hE0, 8'h00);
        send(3, 31, 2'd0, 8'hFF, 8'hE0, 8'h00);
        idle();
        drain("drain_solid");

        // BORDER
        send(0, 5, 2'd1, 8'h03, 8'hE0, 8'hE0);
        send(15, 15, 2'd1, 8'h03, 8'hE0, 8'hE0);
        send(7, 0, 2'd1, 8'h03, 8'hE0, 8'hE0);
        send(1, 1, 2'd1, 8'h03, 8'hE0, 8'h03);
        send(14, 14, 2'd1, 8'h03, 8'hE0, 8'h03);
        send(15, 16, 2'd1, 8'h03, 8'hE0, 8'h00);
        idle();
        drain("drain_border");

        // Back-to-back with mode change between requests
        send(0, 0, 2'd1, 8'h03, 8'hE0, 8'hE0);
        send(1, 1, 2'd3, 8'h03, 8'hE0, 8'h00);
        send(14, 14, 2'd1, 8'h03, 8'hE0, 8'h03);
        idle();
        drain("drain_b2b");

        // BLINK phase progression
        set_mode(2'd2);
        ticks(7);
        chk("blink_after_7", blink_phase, 0);
        ticks(1);
        chk("blink_after_8", blink_phase, 1);
        send(0, 0, 2'd2, 8'h03, 8'hE0, 8'h03);
        send(5, 5, 2'd2, 8'h03, 8'hE0, 8'hE0);
        send(15, 0, 2'd2, 8'h03, 8'hE0, 8'h03);
        send(16, 16, 2'd2, 8'h03, 8'hE0, 8'h00);
        idle();
        drain("drain_blink1");
        ticks(7);
        chk("blink_after_15", blink_phase, 1);
        ticks(1);
        chk("blink_after_16", blink_phase, 0);
        send(0, 5, 2'd2, 8'h03, 8'hE0, 8'hE0);
        send(5, 5, 2'd2, 8'h03, 8'hE0, 8'h03);
        idle();
        drain("drain_blink0");

        // Leaving BLINK at tick 5 restarts the count
        ticks(5);
        set_mode(2'd0);
        set_mode(2'd2);
        ticks(7);
        chk("restart_after_7", blink_phase, 0);
        ticks(1);
        chk("restart_after_8", blink_phase, 1);
        set_mode(2'd0);
        @(negedge clk);
        chk("exit_clears_phase", blink_phase, 0);
        set_mode(2'd2);

        // Tick coincident with exit must not count
        ticks(7);
        @(negedge clk);
        frame_tick = 1'b1;
        mode       = 2'd0;
        @(negedge clk);
        frame_tick = 1'b0;
        mode       = 2'd2;
        chk("tick_exit_phase", blink_phase, 0);
        ticks(7);
        chk("tick_exit_after_7", blink_phase, 0);
        ticks(1);
        chk("tick_exit_after_8", blink_phase, 1);

        // Reset mid-stream with a pixel out and another in flight
        send(0, 0, 2'd2, 8'h03, 8'hE0, 8'h03);
        send(5, 5, 2'd2, 8'h03, 8'hE0, 8'hE0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_reset_valid", pix_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_pix_valid", pix_valid, 0);
        chk("mid_reset_pixels", pixels, 0);
        chk("mid_reset_blink_phase", blink_phase, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 0, 2'd2, 8'h03, 8'hE0, 8'hE0);
        idle();
        drain("drain_after_reset");
        repeat (2) @(negedge clk);
        chk("hold_valid_low", pix_valid, 0);
        chk("hold_pixels", pixels, 8'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
